spi_disp_tx: RTL

Parametrised SPI transmit engine for ST7789-class display panels. It replaces the fixed mode-2, fixed-rate 8-bit shifter with four things: a write FIFO, a programmable SCK divider, runtime-selectable CPOL/CPHA, and a managed chip select. It sits between the display sequencer (init ROM and pixel streamer) and the panel pins, and accepts {DC, data} words over a valid/ready handshake.

---
 rtl/spi_disp_tx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_disp_tx.sv
// spi_disp_tx: SPI transmit engine for ST7789-class panels.
// It has a write FIFO of {DC, payload} words, a programmable SCK half-period,
// runtime CPOL/CPHA selection and a managed chip select. DATA_W must be >= 2.
module spi_disp_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [DIV_W-1:0]                cfg_div_i,
  input  logic                            cfg_cpol_i,
  input  logic                            cfg_cpha_i,
  input  logic                            wr_valid_i,
  input  logic [DATA_W:0]                 wr_data_i,
  output logic                            wr_ready_o,
  output logic                            spi_sck_o,
  output logic                            spi_sda_o,
  output logic                            spi_dc_o,
  output logic                            spi_cs_no,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = DATA_W + 1;
  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LEAD  = 3'd2,
    S_TRAIL = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sck_q, sck_d;
  logic              sda_q, sda_d;
  logic              dc_q, dc_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [WW-1:0]     mem [FIFO_DEPTH];
  logic [WW-1:0]     head;
  logic              push, pop, half_done, last_bit;

  assign push      = wr_valid_i && ready_q;
  assign head      = mem[rd_ptr_q];
  assign half_done = (hcnt_q == div_q);
  assign last_bit  = (bit_q == BW'(DATA_W - 1));

  // FIFO storage; occupancy and pointers live with the other state below
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem[wr_ptr_q] <= wr_data_i;
  end

  // Next-state, pop decision and next pin values
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q + DIV_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sck_d   = sck_q;
    sda_d   = sda_q;
    dc_d    = dc_q;
    cs_d    = cs_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        sck_d  = cfg_cpol_i;
        cs_d   = 1'b1;
        hcnt_d = '0;
        if (level_q != '0) pop = 1'b1;
      end
      S_SETUP: begin
        if (half_done) begin
          state_d = S_LEAD;
          hcnt_d  = '0;
          sck_d   = !cpol_q;
          if (cpha_q) begin
            sda_d = sh_q[DATA_W-1];
            sh_d  = sh_q << 1;
          end
        end
      end
      S_LEAD: begin
        if (half_done) begin
          state_d = S_TRAIL;
          hcnt_d  = '0;
          sck_d   = cpol_q;
          if (!cpha_q && !last_bit) begin
            sda_d = sh_q[DATA_W-2];
            sh_d  = sh_q << 1;
          end
        end
      end
      S_TRAIL: begin
        if (half_done) begin
          hcnt_d = '0;
          if (last_bit) begin
            if (level_q != '0) pop = 1'b1;
            else state_d = S_HOLD;
          end else begin
            state_d = S_LEAD;
            bit_d   = bit_q + BW'(1);
            sck_d   = !cpol_q;
            if (cpha_q) begin
              sda_d = sh_q[DATA_W-1];
              sh_d  = sh_q << 1;
            end
          end
        end
      end
      S_HOLD: begin
        if (half_done) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
          cs_d    = 1'b1;
          sck_d   = cfg_cpol_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word load: config is captured here and held until the next pop
    if (pop) begin
      state_d = S_SETUP;
      hcnt_d  = '0;
      bit_d   = '0;
      sh_d    = head[DATA_W-1:0];
      div_d   = cfg_div_i;
      cpol_d  = cfg_cpol_i;
      cpha_d  = cfg_cpha_i;
      sck_d   = cfg_cpol_i;
      cs_d    = 1'b0;
      dc_d    = head[DATA_W];
      if (!cfg_cpha_i) sda_d = head[DATA_W-1];
    end

    level_d = level_q + LW'(push) - LW'(pop);
    ready_d = (level_d != LW'(FIFO_DEPTH));
    busy_d  = (state_d != S_IDLE) || (level_d != '0);
  end

  // State, counters, FIFO pointers and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sck_q    <= 1'b0;
      sda_q    <= 1'b0;
      dc_q     <= 1'b0;
      cs_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      div_q    <= div_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      sck_q    <= sck_d;
      sda_q    <= sda_d;
      dc_q     <= dc_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      level_q  <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign wr_ready_o = ready_q;
  assign spi_sck_o  = sck_q;
  assign spi_sda_o  = sda_q;
  assign spi_dc_o   = dc_q;
  assign spi_cs_no  = cs_q;
  assign busy_o     = busy_q;
  assign level_o    = level_q;

endmodule
